// File: rtl/udma_hyper_eot_classifier.sv
// Tracks the direction of each launched HyperBus transaction in an in-order FIFO
// and turns controller EOT pulses into registered read-EOT / write-EOT events.
module udma_hyper_eot_classifier #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             trans_push_i,
  input  logic             trans_is_read_i,
  input  logic             eot_i,
  input  logic             err_clr_i,
  output logic             evt_rd_eot_o,
  output logic             evt_wr_eot_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_ovf_o,
  output logic             err_unf_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_dir_q, last_dir_d;
  logic             evt_rd_q, evt_rd_d;
  logic             evt_wr_q, evt_wr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             is_full, is_empty;

  assign is_full  = (cnt_q == FULL_CNT);
  assign is_empty = (cnt_q == '0);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    evt_rd_d   = 1'b0;
    evt_wr_d   = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else if (eot_i) begin
      // Simultaneous push+pop keeps the count, so a full tracker cannot overflow here.
      if (!is_empty) begin
        last_dir_d = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        if (trans_push_i) begin
          mem_d[wr_ptr_q] = trans_is_read_i;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (trans_push_i) begin
        last_dir_d = trans_is_read_i;
      end else begin
        unf_set = 1'b1;
      end
      evt_rd_d = last_dir_d;
      evt_wr_d = !last_dir_d;
    end else if (trans_push_i) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        mem_d[wr_ptr_q] = trans_is_read_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        cnt_d           = cnt_q + CNT_W'(1);
      end
    end

    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
    ovf_d   = (ovf_q && !err_clr_i) || ovf_set;
    unf_d   = (unf_q && !err_clr_i) || unf_set;
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_dir_q <= 1'b0;
      evt_rd_q   <= 1'b0;
      evt_wr_q   <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
      evt_rd_q   <= evt_rd_d;
      evt_wr_q   <= evt_wr_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign evt_rd_eot_o = evt_rd_q;
  assign evt_wr_eot_o = evt_wr_q;
  assign pending_o    = cnt_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign err_ovf_o    = ovf_q;
  assign err_unf_o    = unf_q;

endmodule

// File: tb/tb_udma_hyper_eot_classifier.sv
// Bench for udma_hyper_eot_classifier: directed scenarios plus random traffic
// checked against a queue-based model of the tracker.
module tb_udma_hyper_eot_classifier;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0, clr = 1'b0, push = 1'b0, is_rd = 1'b0, eot = 1'b0, eclr = 1'b0;
  logic             evt_rd, evt_wr, full, empty, ovf, unf;
  logic [CNT_W-1:0] pending;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // reference model state
  bit q[$];
  bit m_last, m_ovf, m_unf, m_erd, m_ewr;

  always #5 clk = ~clk;

  udma_hyper_eot_classifier #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .sys_clk_i(clk), .rst_i(rst), .clr_i(clr), .trans_push_i(push),
    .trans_is_read_i(is_rd), .eot_i(eot), .err_clr_i(eclr),
    .evt_rd_eot_o(evt_rd), .evt_wr_eot_o(evt_wr), .pending_o(pending),
    .full_o(full), .empty_o(empty), .err_ovf_o(ovf), .err_unf_o(unf)
  );

  task automatic model_edge();
    bit d, os, us;
    os = 0; us = 0; m_erd = 0; m_ewr = 0;
    if (rst) begin
      q.delete(); m_last = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (clr) q.delete();
    else if (eot) begin
      if (q.size() > 0) begin
        d = q.pop_front();
        if (push) q.push_back(is_rd);
        m_last = d;
      end else if (push) begin
        d = is_rd; m_last = d;
      end else begin
        d = m_last; us = 1;
      end
      m_erd = d; m_ewr = !d;
    end else if (push) begin
      if (q.size() == DEPTH) os = 1;
      else q.push_back(is_rd);
    end
    m_ovf = (m_ovf && !eclr) || os;
    m_unf = (m_unf && !eclr) || us;
  endtask

  // drive one cycle of inputs, advance past the edge, then release them
  task automatic cyc(input bit p, input bit r, input bit e, input bit c = 0,
                     input bit ec = 0, input bit rs = 0);
    push = p; is_rd = r; eot = e; clr = c; eclr = ec; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    push = 0; is_rd = 0; eot = 0; clr = 0; eclr = 0; rst = 0;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 1);
    total++; if ({evt_rd, evt_wr, full, ovf, unf} !== 5'b0 || pending !== 0 || empty !== 1'b1)
      $display("FAIL reset: ev=%b%b pend=%0d full=%b empty=%b ovf=%b unf=%b, want all 0 except empty=1",
               evt_rd, evt_wr, pending, full, empty, ovf, unf);
    else passed++;
  endtask

  task automatic test_order();
    bit dirs[3] = '{1, 0, 1};
    for (int i = 0; i < 3; i++) begin
      cyc(1, dirs[i], 0);
      total++; if (pending !== CNT_W'(i + 1)) $display("FAIL order_push%0d: pending=%0d want %0d", i, pending, i + 1);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      total++;
      if (evt_rd !== dirs[i] || evt_wr !== !dirs[i] || pending !== CNT_W'(2 - i))
        $display("FAIL order_eot%0d: rd=%b wr=%b pend=%0d want rd=%b wr=%b pend=%0d",
                 i, evt_rd, evt_wr, pending, dirs[i], !dirs[i], 2 - i);
      else passed++;
    end
    cyc(0, 0, 0);
    total++; if (evt_rd !== 0 || evt_wr !== 0) $display("FAIL order_idle: rd=%b wr=%b want 0 0", evt_rd, evt_wr);
    else passed++;
  endtask

  task automatic test_overflow();
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    total++; if (full !== 1 || pending !== 4 || ovf !== 0)
      $display("FAIL ovf_fill: full=%b pend=%0d ovf=%b want 1 4 0", full, pending, ovf);
    else passed++;
    cyc(1, 1, 0);
    total++; if (ovf !== 1 || pending !== 4) $display("FAIL ovf_drop: ovf=%b pend=%0d want 1 4", ovf, pending);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      total++; if (evt_wr !== 1 || evt_rd !== 0) $display("FAIL ovf_drain%0d: rd=%b wr=%b want 0 1", i, evt_rd, evt_wr);
      else passed++;
    end
    total++; if (empty !== 1) $display("FAIL ovf_empty: empty=%b want 1", empty);
    else passed++;
    cyc(0, 0, 0, 0, 1);
    total++; if (ovf !== 0) $display("FAIL ovf_clear: ovf=%b want 0", ovf);
    else passed++;
  endtask

  task automatic test_bypass_underflow();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1);
    total++; if (evt_rd !== 1 || evt_wr !== 0 || pending !== 0 || empty !== 1 || unf !== 0 || ovf !== 0)
      $display("FAIL bypass: rd=%b wr=%b pend=%0d empty=%b unf=%b ovf=%b want 1 0 0 1 0 0",
               evt_rd, evt_wr, pending, empty, unf, ovf);
    else passed++;
    cyc(0, 0, 1);
    total++; if (evt_rd !== 1 || evt_wr !== 0 || unf !== 1)
      $display("FAIL underflow: rd=%b wr=%b unf=%b want 1 0 1", evt_rd, evt_wr, unf);
    else passed++;
    cyc(0, 0, 1, 0, 1);
    total++; if (unf !== 1) $display("FAIL unf_set_wins: unf=%b want 1", unf);
    else passed++;
    cyc(0, 0, 0, 0, 1);
    total++; if (unf !== 0) $display("FAIL unf_clear: unf=%b want 0", unf);
    else passed++;
  endtask

  task automatic test_full_pushpop();
    bit want[4] = '{0, 0, 0, 1};
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(1, 1, 1);
    total++; if (evt_wr !== 1 || evt_rd !== 0 || pending !== 4 || ovf !== 0 || full !== 1)
      $display("FAIL full_pushpop: rd=%b wr=%b pend=%0d ovf=%b full=%b want 0 1 4 0 1",
               evt_rd, evt_wr, pending, ovf, full);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      total++; if (evt_rd !== want[i] || evt_wr !== !want[i])
        $display("FAIL full_drain%0d: rd=%b wr=%b want %b %b", i, evt_rd, evt_wr, want[i], !want[i]);
      else passed++;
    end
  endtask

  task automatic test_clr_rst();
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    cyc(0, 0, 1, 1);
    total++; if (evt_rd !== 0 || evt_wr !== 0 || pending !== 0 || empty !== 1 || unf !== 0)
      $display("FAIL clr: rd=%b wr=%b pend=%0d empty=%b unf=%b want 0 0 0 1 0", evt_rd, evt_wr, pending, empty, unf);
    else passed++;
    cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);
    total++; if ({evt_rd, evt_wr, full, ovf, unf} !== 5'b0 || pending !== 0 || empty !== 1)
      $display("FAIL rst_mid: ev=%b%b pend=%0d full=%b empty=%b ovf=%b unf=%b want all 0 except empty=1",
               evt_rd, evt_wr, pending, full, empty, ovf, unf);
    else passed++;
  endtask

  task automatic test_random();
    int unsigned errs = 0;
    cyc(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 2000; n++) begin
      cyc($urandom_range(0, 99) < 50, $urandom_range(0, 1), $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, $urandom_range(0, 299) == 0);
      total++;
      if (evt_rd !== m_erd || evt_wr !== m_ewr || pending !== CNT_W'(q.size()) ||
          full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || ovf !== m_ovf || unf !== m_unf) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got rd=%b wr=%b pend=%0d full=%b empty=%b ovf=%b unf=%b want %b %b %0d %b %b %b %b",
                   n, evt_rd, evt_wr, pending, full, empty, ovf, unf,
                   m_erd, m_ewr, q.size(), q.size() == DEPTH, q.size() == 0, m_ovf, m_unf);
        errs++;
      end else passed++;
      total++; if (evt_rd === 1'b1 && evt_wr === 1'b1) $display("FAIL random_excl[%0d]: both events high", n);
      else passed++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_order();
    test_overflow();
    test_bypass_underflow();
    test_full_pushpop();
    test_clr_rst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
